// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared defaults, drain FSM state type and index-width helper
//               for the MAC array result path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int C_ACC_W  = 16;
    localparam int C_N_MACS = 4;

    // Never returns 0 so single-lane builds still get a legal index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int C_IDX_W = idx_width(C_N_MACS);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_lane_pick.sv
// ============================================================================
// Module      : mac_lane_pick
// Description : Combinational set-bit finder. With i_first high it returns the
//               lowest set bit of i_mask; otherwise the lowest set bit above
//               i_ptr. o_is_last flags that no set bit lies above i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_lane_pick
    import mac_pkg::*;
#(
    parameter int N_MACS = C_N_MACS,
    parameter int IDX_W  = idx_width(N_MACS)
) (
    input  logic [N_MACS-1:0] i_mask,
    input  logic [IDX_W-1:0]  i_ptr,
    input  logic              i_first,
    output logic [IDX_W-1:0]  o_next_ptr,
    output logic              o_is_last,
    output logic              o_none
);

    always_comb begin
        o_next_ptr = '0;
        o_is_last  = 1'b1;
        o_none     = 1'b1;
        // Descending scan: the last hit written is the lowest qualifying lane.
        for (int i = N_MACS - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_first || (IDX_W'(i) > i_ptr))) begin
                o_next_ptr = IDX_W'(i);
                o_none     = 1'b0;
            end
            if (i_mask[i] && (IDX_W'(i) > i_ptr)) begin
                o_is_last = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_array_drain.sv
// ============================================================================
// Module      : mac_array_drain
// Description : Captures per-lane MAC results, then streams a full frame out
//               lane-by-lane over valid/ready, pulsing a per-lane clear as
//               each result is consumed. Optional macro DRAIN_RELU_EN clamps
//               negative results to zero at the output mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_array_drain
    import mac_pkg::*;
#(
    parameter int ACC_W  = C_ACC_W,
    parameter int N_MACS = C_N_MACS,
    parameter int IDX_W  = idx_width(N_MACS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MACS*ACC_W-1:0] acc_in,
    input  logic [N_MACS-1:0]       acc_valid,
    input  logic [N_MACS-1:0]       lane_mask,
    output logic [ACC_W-1:0]        out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [N_MACS-1:0]       clear_out,
    output logic                    overflow,
    input  logic                    overflow_clr,
    output logic                    busy
);

    drain_state_t        r_state;
    drain_state_t        w_state_nxt;
    logic [ACC_W-1:0]    r_hold [N_MACS];
    logic [N_MACS-1:0]   r_full;
    logic [N_MACS-1:0]   r_frame_mask;
    logic [N_MACS-1:0]   w_frame_mask_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [N_MACS-1:0]   r_clear;
    logic                r_overflow;

    logic                w_send;
    logic                w_hs;
    logic [ACC_W-1:0]    w_slice [N_MACS];
    logic [N_MACS-1:0]   w_hs_lane;
    logic [N_MACS-1:0]   w_take;
    logic [N_MACS-1:0]   w_collide;
    logic [ACC_W-1:0]    w_sel;
    logic [ACC_W-1:0]    w_sel_out;

    logic [IDX_W-1:0]    w_next_ptr;
    logic                w_is_last;
    logic [IDX_W-1:0]    w_first_ptr;
    logic                w_first_none;
    logic                w_unused_pick;
    logic                w_next_none;
    logic                w_first_last;

    mac_lane_pick #(
        .N_MACS (N_MACS),
        .IDX_W  (IDX_W)
    ) u_pick_next (
        .i_mask     (r_frame_mask),
        .i_ptr      (r_ptr),
        .i_first    (1'b0),
        .o_next_ptr (w_next_ptr),
        .o_is_last  (w_is_last),
        .o_none     (w_next_none)
    );

    mac_lane_pick #(
        .N_MACS (N_MACS),
        .IDX_W  (IDX_W)
    ) u_pick_first (
        .i_mask     (lane_mask),
        .i_ptr      ('0),
        .i_first    (1'b1),
        .o_next_ptr (w_first_ptr),
        .o_is_last  (w_first_last),
        .o_none     (w_first_none)
    );

    assign w_unused_pick = w_next_none ^ w_first_last;

    assign w_hs = w_send && out_ready;

    // A lane being consumed this cycle may accept a fresh result without it
    // counting as a collision: the old value leaves as the new one lands.
    for (genvar i = 0; i < N_MACS; i++) begin : g_lane
        assign w_slice[i]   = acc_in[i*ACC_W +: ACC_W];
        assign w_hs_lane[i] = w_hs && (r_ptr == IDX_W'(i));
        assign w_take[i]    = acc_valid[i] && lane_mask[i] && (!r_full[i] || w_hs_lane[i]);
        assign w_collide[i] = acc_valid[i] && lane_mask[i] && r_full[i] && !w_hs_lane[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MACS; i++) begin
                r_hold[i] <= '0;
            end
            r_full     <= '0;
            r_overflow <= 1'b0;
            r_clear    <= '0;
        end else begin
            for (int i = 0; i < N_MACS; i++) begin
                if (w_take[i]) begin
                    r_hold[i] <= w_slice[i];
                end
            end
            r_full  <= w_take | (r_full & ~w_hs_lane);
            r_clear <= w_hs ? (N_MACS'(1) << r_ptr) : '0;
            if (|w_collide) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= COLLECT;
            r_frame_mask <= '0;
            r_ptr        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_mask <= w_frame_mask_nxt;
            r_ptr        <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_mask_nxt = r_frame_mask;
        w_ptr_nxt        = r_ptr;
        w_send           = 1'b0;
        case (r_state)
            COLLECT: begin
                if (!w_first_none && ((r_full & lane_mask) == lane_mask)) begin
                    w_state_nxt      = SEND;
                    w_frame_mask_nxt = lane_mask;
                    w_ptr_nxt        = w_first_ptr;
                end
            end
            SEND: begin
                w_send = 1'b1;
                if (out_ready) begin
                    w_ptr_nxt = w_next_ptr;
                    if (w_is_last) begin
                        w_state_nxt = COLLECT;
                    end
                end
            end
        endcase
    end

    assign w_sel = r_hold[r_ptr];

`ifdef DRAIN_RELU_EN
    assign w_sel_out = w_sel[ACC_W-1] ? '0 : w_sel;
`else
    assign w_sel_out = w_sel;
`endif

    // Outputs depend only on registered state, never on out_ready.
    assign out_valid = w_send;
    assign busy      = w_send;
    assign out_data  = w_send ? w_sel_out : '0;
    assign out_idx   = w_send ? r_ptr : '0;
    assign out_last  = w_send && w_is_last;
    assign clear_out = r_clear;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mac_array_drain.sv
// ============================================================================
// Module      : tb_mac_array_drain
// Description : Self-checking bench for mac_array_drain; expected output
//               stream derived from frame contents. Honours DRAIN_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mac_array_drain;

    localparam int ACC_W = 16;
    localparam int N     = 4;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*ACC_W-1:0] acc_in;
    logic [N-1:0]      acc_valid;
    logic [N-1:0]      lane_mask;
    logic [ACC_W-1:0]  out_data;
    logic [IW-1:0]     out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [N-1:0]      clear_out;
    logic              overflow;
    logic              overflow_clr;
    logic              busy;

    always #5 clk = ~clk;

    mac_array_drain #(
        .ACC_W  (ACC_W),
        .N_MACS (N),
        .IDX_W  (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .acc_in       (acc_in),
        .acc_valid    (acc_valid),
        .lane_mask    (lane_mask),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .clear_out    (clear_out),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;

    beat_t            exp_q[$];
    beat_t            rx_q[$];
    beat_t            cmp_e;
    logic [N-1:0]     pend_clr = '0;
    bit               stall_seen = 1'b0;
    logic [ACC_W-1:0] stall_data;
    logic [IW-1:0]    stall_idx;
    logic             stall_last;

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected stream for one frame: enabled lanes in ascending order, the
    // last one flagged, data optionally rectified.
    task automatic push_frame(input logic [N-1:0] m, input int vals[4]);
        int hi = -1;
        int d;
        for (int i = 0; i < N; i++) if (m[i]) hi = i;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                d = vals[i];
`ifdef DRAIN_RELU_EN
                if (d < 0) d = 0;
`endif
                exp_q.push_back('{i, d, (i == hi)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            pend_clr   = '0;
            stall_seen = 1'b0;
            check("rst_valid", out_valid, 0);
            check("rst_clear", clear_out, 0);
        end else begin
            check("clear_out", clear_out, pend_clr);
            pend_clr = '0;
            check("busy", busy, out_valid);
            if (stall_seen) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
                check("stall_idx", out_idx, stall_idx);
                check("stall_last", out_last, stall_last);
            end
            stall_seen = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: idx %0d data %0d with nothing expected",
                             out_idx, $signed(out_data));
                end else if (out_ready) begin
                    cmp_e = exp_q.pop_front();
                    check("beat_idx", out_idx, cmp_e.idx);
                    check("beat_data", $signed(out_data), cmp_e.data);
                    check("beat_last", out_last, cmp_e.last);
                    rx_q.push_back('{int'(out_idx), int'($signed(out_data)), out_last});
                    pend_clr = N'(1) << out_idx;
                end else begin
                    stall_seen = 1'b1;
                    stall_data = out_data;
                    stall_idx  = out_idx;
                    stall_last = out_last;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic deliver(input logic [N-1:0] v, input int vals[4]);
        for (int i = 0; i < N; i++) begin
            if (v[i]) acc_in[i*ACC_W +: ACC_W] = ACC_W'(vals[i]);
        end
        acc_valid = v;
        tick();
        acc_valid = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: drain not finished after %0d cycles, %0d beats left", name, n, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: out_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic check_rx(input string name, input int n, input int ei[4], input int ed[4],
                            input bit el[4]);
        check({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check({name, "_idx"}, rx_q[i].idx, ei[i]);
            check({name, "_data"}, rx_q[i].data, ed[i]);
            check({name, "_last"}, rx_q[i].last, el[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        acc_in       = '0;
        acc_valid    = '0;
        lane_mask    = '0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_last", out_last, 0);
        check("reset_clear_out", clear_out, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        tick();

        // Full frame, one capture per cycle, ready held high.
        rx_q.delete();
        lane_mask = 4'b1111;
        out_ready = 1'b1;
        push_frame(4'b1111, '{5, -3, 100, -128});
        deliver(4'b0001, '{5, 0, 0, 0});
        deliver(4'b0010, '{0, -3, 0, 0});
        deliver(4'b0100, '{0, 0, 100, 0});
        deliver(4'b1000, '{0, 0, 0, -128});
        check("lat_not_yet_valid", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_first_idx", out_idx, 0);
        tick();
        tick();
        tick();
        check("b2b_idx3", out_idx, 3);
        check("b2b_last3", out_last, 1);
        tick();
        check("b2b_done", out_valid, 0);
        wait_drain("frame1", 20);
`ifdef DRAIN_RELU_EN
        check_rx("frame1", 4, '{0, 1, 2, 3}, '{5, 0, 100, 0}, '{0, 0, 0, 1});
`else
        check_rx("frame1", 4, '{0, 1, 2, 3}, '{5, -3, 100, -128}, '{0, 0, 0, 1});
`endif

        // Sparse mask; masked-off lane 0 strobe must be ignored.
        rx_q.delete();
        lane_mask = 4'b1010;
        push_frame(4'b1010, '{0, 7, 0, 9});
        deliver(4'b1011, '{55, 7, 0, 9});
        wait_drain("frame2", 20);
        check_rx("frame2", 2, '{1, 3, 0, 0}, '{7, 9, 0, 0}, '{0, 1, 0, 0});
        check("frame2_overflow", overflow, 0);

        // Backpressure: outputs hold while ready is low.
        rx_q.delete();
        lane_mask = 4'b1111;
        out_ready = 1'b0;
        push_frame(4'b1111, '{11, 22, 33, 44});
        deliver(4'b1111, '{11, 22, 33, 44});
        wait_valid("stall_start", 10);
        repeat (5) tick();
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_idx", out_idx, 0);
        check("stall_hold_data", out_data, 11);
        check("stall_no_clear", clear_out, 0);
        out_ready = 1'b1;
        wait_drain("frame3", 20);
        check_rx("frame3", 4, '{0, 1, 2, 3}, '{11, 22, 33, 44}, '{0, 0, 0, 1});

        // Collision on a held lane: old value kept, overflow sticky, set beats clear.
        rx_q.delete();
        lane_mask = 4'b1100;
        push_frame(4'b1100, '{0, 0, 17, 3});
        deliver(4'b0100, '{0, 0, 17, 0});
        check("ovf_before", overflow, 0);
        overflow_clr = 1'b1;
        deliver(4'b0100, '{0, 0, 42, 0});
        overflow_clr = 1'b0;
        check("ovf_set_wins", overflow, 1);
        tick();
        check("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        deliver(4'b1000, '{0, 0, 0, 3});
        wait_drain("frame4", 20);
        check_rx("frame4", 2, '{2, 3, 0, 0}, '{17, 3, 0, 0}, '{0, 1, 0, 0});

        // Reset mid-frame after two beats.
        rx_q.delete();
        lane_mask = 4'b1111;
        out_ready = 1'b0;
        push_frame(4'b1111, '{1, 2, 3, 4});
        deliver(4'b1111, '{1, 2, 3, 4});
        wait_valid("abort_start", 10);
        out_ready = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_idx", out_idx, 0);
        check("abort_last", out_last, 0);
        check("abort_clear", clear_out, 0);
        check("abort_busy", busy, 0);
        tick();
        tick();
        check("abort_clear_later", clear_out, 0);
        check_rx("abort", 2, '{0, 1, 0, 0}, '{1, 2, 0, 0}, '{0, 0, 0, 0});
        rst = 1'b1;
        tick();
        rx_q.delete();
        lane_mask = 4'b0011;
        out_ready = 1'b1;
        push_frame(4'b0011, '{8, 9, 0, 0});
        deliver(4'b0011, '{8, 9, 0, 0});
        wait_drain("post_abort", 20);
        check_rx("post_abort", 2, '{0, 1, 0, 0}, '{8, 9, 0, 0}, '{0, 1, 0, 0});

        // Signed values around zero, rectified when the feature is built in.
        rx_q.delete();
        lane_mask = 4'b1111;
        push_frame(4'b1111, '{-5, 6, 0, -1});
        deliver(4'b1111, '{-5, 6, 0, -1});
        wait_drain("frame6", 20);
`ifdef DRAIN_RELU_EN
        check_rx("frame6", 4, '{0, 1, 2, 3}, '{0, 6, 0, 0}, '{0, 0, 0, 1});
`else
        check_rx("frame6", 4, '{0, 1, 2, 3}, '{-5, 6, 0, -1}, '{0, 0, 0, 1});
`endif

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
